// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_pipe_slice.sv
// One valid/ready register slice with no skid buffer.
// Advances whenever it is empty or its consumer takes the held entry.
module logic_pipe_slice #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    input  logic         dn_ready
);

    assign up_ready = ~dn_valid | dn_ready;

    // NOTE: non-blocking assignments, so every slice samples its neighbour's pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            // NOTE: the data register is reset as well, so out_result and out_zero read 0 after reset.
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            dn_data  <= up_data;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: one of eight ops on two operands.
// The zero flag is carried alongside the result through STAGES slices.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    localparam int W = WIDTH + 1;

    logic [WIDTH-1:0] op_result;
    logic             op_zero;

    always_comb begin
        // NOTE: the default comes first, so every path assigns op_result and no latch is inferred.
        op_result = in_a;
        case (op_e'(in_op))
            OP_NOT:  op_result = ~in_a;
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_XOR:  op_result = in_a ^ in_b;
            OP_NAND: op_result = ~(in_a & in_b);
            OP_NOR:  op_result = ~(in_a | in_b);
            OP_XNOR: op_result = ~(in_a ^ in_b);
            default: op_result = in_a;
        endcase
    end

    assign op_zero = (op_result == '0);

    // Each stage owns its link signals, so the ready chain is not one shared vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic         up_valid;
        logic         up_ready;
        logic [W-1:0] up_data;
        logic         dn_valid;
        logic         dn_ready;
        logic [W-1:0] dn_data;

        if (i == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = {op_zero, op_result};
        end else begin : g_link
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
        end

        if (i == STAGES - 1) begin : g_last
            assign dn_ready = out_ready;
        end else begin : g_mid
            assign dn_ready = g_stage[i+1].up_ready;
        end

        logic_pipe_slice #(.W(W)) u_slice (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_ready (up_ready),
            .dn_valid (dn_valid),
            .dn_data  (dn_data),
            .dn_ready (dn_ready)
        );
    end

    assign in_ready               = g_stage[0].up_ready;
    assign out_valid              = g_stage[STAGES-1].dn_valid;
    assign {out_zero, out_result} = g_stage[STAGES-1].dn_data;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: default 16x2 instance plus an 8x4 instance.
module tb_logic_unit_pipe;
    import logic_unit_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b, out_result;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_zero;
    logic [2:0]  s_in_op;
    logic [7:0]  s_in_a, s_in_b, s_out_result;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_dut_w8s4 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op), .in_a(s_in_a), .in_b(s_in_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
        .out_zero(s_out_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the 16x2 unit: drive inputs, score any output pop, queue any accepted push.
    task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input logic ordy);
        logic [15:0] e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_result), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(out_result), 32'(e));
                check("zero", 32'(out_zero), 32'(e == 16'h0000));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(exp);
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, OP_PASS, '0, '0, '0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t2_exp[8];
        logic [2:0]  t5_op[6];
        logic [15:0] t5_a[6], t5_b[6], t5_exp[6];
        int acc;

        t2_exp = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        t5_op  = '{OP_PASS, OP_XNOR, OP_NOR, OP_AND, OP_OR, OP_XOR};
        t5_a   = '{16'h3333, 16'hAAAA, 16'h0F0F, 16'h1234, 16'h0000, 16'hFFFF};
        t5_b   = '{16'hFFFF, 16'h5555, 16'h00F0, 16'hFFFF, 16'h0000, 16'hFFFF};
        t5_exp = '{16'h3333, 16'h0000, 16'hF000, 16'h1234, 16'h0000, 16'h0000};

        // Reset held two cycles
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_op = '0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // All eight ops streamed back-to-back
        for (int i = 0; i < 8; i++) begin
            if (i == 1) check("lat_cycle1_valid", 32'(out_valid), 32'd0);
            if (i == 2) check("lat_cycle2_valid", 32'(out_valid), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            step(1'b1, 3'(i), 16'hF0F0, 16'hFF00, t2_exp[i], 1'b1);
        end
        drain();

        // Zero flag from AND and from NOT
        step(1'b1, OP_AND, 16'h00FF, 16'hFF00, 16'h0000, 1'b1);
        step(1'b1, OP_NOT, 16'hFFFF, 16'h1234, 16'h0000, 1'b1);
        drain();

        // Backpressure: two accepts, then stall with the first result held
        step(1'b1, OP_XOR, 16'h1234, 16'h00FF, 16'h12CB, 1'b0);
        step(1'b1, OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0);
        step(1'b1, OP_NAND, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_result", 32'(out_result), 32'h12CB);
        step(1'b1, OP_NAND, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0);
        check("bp_hold_result2", 32'(out_result), 32'h12CB);
        check("bp_hold_zero", 32'(out_zero), 32'd0);
        check("bp_accepts", 32'(exp_q.size()), 32'd2);
        step(1'b1, OP_NAND, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b1);
        drain();

        // Full pipe with simultaneous pop and push every cycle
        step(1'b1, OP_PASS, 16'h1111, 16'hFFFF, 16'h1111, 1'b0);
        step(1'b1, OP_PASS, 16'h2222, 16'hFFFF, 16'h2222, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("pt_out_valid", 32'(out_valid), 32'd1);
            step(1'b1, t5_op[i], t5_a[i], t5_b[i], t5_exp[i], 1'b1);
            check("pt_in_ready", 32'(in_ready), 32'd1);
            check("pt_occupancy", 32'(exp_q.size()), 32'd2);
        end
        drain();

        // Mid-flight reset discards two in-flight results
        step(1'b1, OP_AND, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0);
        step(1'b1, OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0);
        rst = 1'b1;
        step(1'b0, OP_PASS, '0, '0, '0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_result", 32'(out_result), 32'd0);
        check("mrst_out_zero", 32'(out_zero), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, OP_PASS, '0, '0, '0, 1'b1);
            check("mrst_ghost", 32'(out_valid), 32'd0);
        end

        // 8-bit, 4-stage instance: latency and fill depth
        s_in_valid = 1'b1; s_in_op = OP_XOR; s_in_a = 8'hA5; s_in_b = 8'h0F; s_out_ready = 1'b1;
        #1;
        check("w8_in_ready", 32'(s_in_ready), 32'd1);
        tick();
        s_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("w8_lat_valid", 32'(s_out_valid), 32'd0);
            tick();
        end
        check("w8_out_valid", 32'(s_out_valid), 32'd1);
        check("w8_out_result", 32'(s_out_result), 32'hAA);
        check("w8_out_zero", 32'(s_out_zero), 32'd0);
        tick();
        check("w8_popped", 32'(s_out_valid), 32'd0);
        acc = 0;
        s_out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_in_valid = 1'b1; s_in_op = OP_PASS; s_in_a = 8'(8'h3C + k); s_in_b = 8'hFF;
            #1;
            if (s_in_ready) acc++;
            tick();
        end
        s_in_valid = 1'b0;
        check("w8_fill_accepts", 32'(acc), 32'd4);
        check("w8_fill_head", 32'(s_out_result), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
